// File: rtl/freq_gate_if.sv
// Handshake bundle between the frequency-measurement sequencer and its controller/readout.
interface freq_gate_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             start;
    logic             cont;
    logic             abort;
    logic             sig_in;
    logic             result_ack;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             overflow;
    logic             overrun;

    // Controller / consumer side
    modport master (
        output start, cont, abort, sig_in, result_ack,
        input  busy, result, result_valid, overflow, overrun
    );

    // Sequencer side
    modport slave (
        input  start, cont, abort, sig_in, result_ack,
        output busy, result, result_valid, overflow, overrun
    );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Frequency-counter measurement sequencer: opens a GATE_CYCLES-long window, counts
// synchronized rising edges of sig_in, and hands the count out with a valid/ack handshake.
module freq_gate_ctrl #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 32
) (
    input logic        clk,
    input logic        rst,
    freq_gate_if.slave bus
);

    localparam int unsigned      TW        = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]    TimerLast = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    typedef enum logic [1:0] {StIdle, StArm, StGate, StLatch} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             edge_det;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             ovr_q, ovr_d;

    // Synchronizer plus delay flop; runs in every state so no edge is manufactured at arm time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_det = s2_q & ~s3_q;

    // State, gate timer, edge counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state: sequencing, saturating edge count, latch and handshake bookkeeping
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        result_d = result_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        ovr_d    = ovr_q;

        // Ack only acts on a pending result; a same-cycle latch below re-asserts valid
        if (bus.result_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if ((bus.start || bus.cont) && !bus.abort) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                timer_d = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
                state_d = StGate;
            end
            StGate: begin
                timer_d = timer_q + 1'b1;
                if (edge_det) begin
                    if (cnt_q == CntMax) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (timer_q == TimerLast) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                // Abort wins over the load: the finished count is dropped
                if (!bus.abort) begin
                    result_d = cnt_q;
                    ovf_d    = sat_q;
                    valid_d  = 1'b1;
                    if (valid_q && !bus.result_ack) begin
                        ovr_d = 1'b1;
                    end
                end
                state_d = bus.cont ? StArm : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.overflow     = ovf_q;
    assign bus.overrun      = ovr_q;

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Measurement sequencer for the frequency counter.
- Opens a fixed gate window of GATE_CYCLES clk periods (1 s at 50 MHz by default) and counts rising edges of an asynchronous input during the window.
- Latches the count as the measured frequency and presents it to the display/readout logic with a valid/ack handshake.
- Supports single-shot and continuous (back-to-back) measurement.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk cycles; legal range >= 2.
- CNT_W, 32, width of the edge counter and of result.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin one measurement.
- cont  in  1  continuous mode: re-arm automatically after each latch; sampled in LATCH.
- abort  in  1  synchronous cancel of the measurement in progress.
- sig_in  in  1  asynchronous signal under measurement.
- result_ack  in  1  single-cycle acknowledge from the consumer.
- busy  out  1  high in ARM, GATE and LATCH.
- result  out  CNT_W  edge count latched at the end of the last completed gate.
- result_valid  out  1  result holds an unacknowledged measurement.
- overflow  out  1  latched with result: the count saturated during that gate.
- overrun  out  1  sticky: a new result replaced an unacknowledged one.

Behaviour:
- Reset (asynchronous): state=IDLE, all counters, synchronizer flops, busy, result, result_valid, overflow and overrun cleared to 0.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer s1->s2, then a delay flop s3.
  - edge = s2 & ~s3.
  - A sig_in rise reaches edge 2-3 clk later. Edges still in the pipe at gate close are not counted.
  - The synchronizer runs in every state and is never cleared except by rst.
- IDLE: busy=0.
  - start=1 or cont=1 -> ARM.
  - start with abort=1 in the same cycle -> stay IDLE.
- ARM (1 cycle): gate timer=0, edge counter=0, sat flag=0 -> GATE.
- GATE:
  - Timer increments each cycle.
  - Each edge=1 increments the edge counter. At all-ones the counter holds and sat is set.
  - Edges are counted in every GATE cycle, including the cycle with timer=GATE_CYCLES-1.
  - Timer==GATE_CYCLES-1 -> LATCH. Exactly GATE_CYCLES cycles are spent in GATE.
- LATCH (1 cycle):
  - result<=counter, overflow<=sat, result_valid<=1.
  - If result_valid was already 1 and result_ack=0 in this cycle, overrun<=1.
  - Next state: cont=1 -> ARM, else IDLE.
- Timing: with start sampled at edge 0, ARM is cycle 1, GATE is cycles 2..GATE_CYCLES+1, LATCH is cycle GATE_CYCLES+2, and result_valid is first high in cycle GATE_CYCLES+3.
- Handshake:
  - result_ack=1 clears result_valid and overrun on the next edge.
  - result, overflow and overrun remain stable while result_valid=1, except on a LATCH (new result replaces old).
  - ack and LATCH in the same cycle: the new result is loaded, result_valid stays 1, overrun is not set.
  - result_ack with result_valid=0 has no effect.
- start while busy=1 is ignored (not queued).
- abort=1 in ARM, GATE or LATCH:
  - Next state is IDLE and the partial count is discarded.
  - result, result_valid, overflow and overrun are unchanged, including in LATCH: abort takes priority, so no new result is loaded.
  - abort in IDLE has no effect.
- cont deasserted during GATE: the current measurement completes, then the block goes to IDLE.
- rst asserted mid-measurement: immediate return to IDLE with outputs 0. There is no pending result after reset.
- Widths:
  - Gate timer width is $clog2(GATE_CYCLES).
  - Edge counter saturates; it never wraps.

Test Plan:
- GATE_CYCLES=100, CNT_W=32, sig_in period 10 clk, start pulse at cycle 0 -> busy high cycles 1..102; result_valid rises in cycle 103; result=10 (±1 for edge alignment), overflow=0.
- CNT_W=4, GATE_CYCLES=100, sig_in period 2 clk -> result=15, overflow=1; counter does not wrap.
- cont=1, no ack, sig_in period 20 -> first result=5 with overrun=0; second LATCH gives result=5 with overrun=1; ack -> result_valid=0, overrun=0 next cycle.
- result_ack pulsed exactly in a LATCH cycle (cont=1) -> result_valid stays 1, overrun stays 0.
- abort at GATE cycle 50 -> busy=0 next cycle; result_valid and result keep their prior values; a following start gives a full-length gate.
- rst pulsed mid-GATE -> all outputs 0 asynchronously. start during busy at cycle 20 -> ignored; measurement length unchanged.
